bus_uart_tx: RTL

//  Memory-mapped UART transmitter (8N1) on the shared Cpu bus, beside the block RAM.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/bus_uart_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the DIVISOR write-merge helper.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Byte-lane merge of a DIVISOR write; a zero divisor would stall the bit timer, so it becomes 1.
  function automatic logic [15:0] div_merge(input logic [15:0] cur,
                                            input logic [15:0] wdata,
                                            input logic [1:0]  mask);
    logic [15:0] v;
    v = cur;
    if (mask[0]) v[7:0]  = wdata[7:0];
    if (mask[1]) v[15:8] = wdata[15:8];
    if (v == 16'd0) v = 16'd1;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is dropped unless
// a pop happens in the same cycle, and o_drop flags the dropped push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register window decode, registered read port,
// TX FIFO and the bit-timed serialiser FSM.
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  input  logic        bus_write,
  output logic [31:0] bus_data_r,
  output logic        bus_hit,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_ovf_clr;
  logic        w_div_wr;
  logic [7:0]  w_fifo_data;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic        w_drop;
  logic        w_busy;
  logic        w_bit_end;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic [17:0] w_unused;

  logic [15:0] r_div;
  logic        r_ovf;
  logic [31:0] r_data_r;
  logic        r_hit;

  uart_state_t r_state, w_state_next;
  logic [15:0] r_timer, w_timer_next;
  logic [2:0]  r_bitcnt, w_bitcnt_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [15:0] r_divq, w_divq_next;
  logic        r_tx, w_tx_next;

  assign w_unused  = {bus_data_w[31:16], bus_mask_w[3:2]};

  assign w_hit     = (bus_addr[31:2] == BASE_ADDR[31:2]);
  assign w_off     = bus_addr[1:0];
  assign w_wr      = w_hit && bus_write;
  assign w_push    = w_wr && (w_off == REG_TXDATA) && bus_mask_w[0];
  assign w_ovf_clr = w_wr && (w_off == REG_STATUS) && bus_mask_w[0] && bus_data_w[3];
  assign w_div_wr  = w_wr && (w_off == REG_DIVISOR) && (|bus_mask_w[1:0]);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (bus_data_w[7:0]),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_drop    (w_drop)
  );

  assign w_busy   = (r_state != IDLE);
  assign w_status = {16'b0, 8'(w_count), 4'b0, r_ovf, w_busy, w_empty, w_full};

  always_comb begin
    w_rdata = 32'b0;
    case (w_off)
      REG_STATUS:  w_rdata = w_status;
      REG_DIVISOR: w_rdata = {16'b0, r_div};
      default:     w_rdata = 32'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div    <= DIV_RESET;
      r_ovf    <= 1'b0;
      r_data_r <= 32'b0;
      r_hit    <= 1'b0;
    end else begin
      r_hit    <= w_hit;
      r_data_r <= w_hit ? w_rdata : 32'b0;
      if (w_div_wr) r_div <= div_merge(r_div, bus_data_w[15:0], bus_mask_w[1:0]);
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus_data_r = r_data_r;
  assign bus_hit    = r_hit;
  assign tx         = r_tx;

  // r_divq is never zero once a frame starts, so divq-1 cannot wrap during a frame.
  assign w_bit_end = (r_timer == (r_divq - 16'd1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_timer  <= 16'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_divq   <= DIV_RESET;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_bitcnt <= w_bitcnt_next;
      r_shift  <= w_shift_next;
      r_divq   <= w_divq_next;
      r_tx     <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_bitcnt_next = r_bitcnt;
    w_shift_next  = r_shift;
    w_divq_next   = r_divq;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_data;
          w_divq_next  = r_div;
          w_timer_next = 16'd0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_timer_next  = 16'd0;
          w_bitcnt_next = 3'd0;
          w_state_next  = DATA;
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_timer_next = 16'd0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bitcnt == 3'd7) w_state_next = STOP;
          else                  w_bitcnt_next = r_bitcnt + 3'd1;
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_timer_next = 16'd0;
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // tx is registered from the next-state view so the line never glitches on decode.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule
